// File: rtl/led_stretcher_if.sv
// LED stretcher channel bundle: event requests in, LED drive and busy flags out.
interface led_stretcher_if #(
    parameter int unsigned NOUT = 8
);

    logic [NOUT-1:0] i_event;
    logic [NOUT-1:0] o_led;
    logic [NOUT-1:0] o_busy;

    // Event source / LED consumer side
    modport master (
        output i_event,
        input  o_led,
        input  o_busy
    );

    // Stretcher side
    modport slave (
        input  i_event,
        output o_led,
        output o_busy
    );

endinterface : led_stretcher_if

// File: rtl/led_stretcher.sv
// Per-channel LED pulse stretcher: a short event lights the LED fully for a
// hold period, then the LED fades out linearly via a shared PWM counter.
module led_stretcher #(
    parameter int unsigned NOUT   = 8,
    parameter int unsigned LGHOLD = 17,
    parameter int unsigned LGPWM  = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    led_stretcher_if.slave   led_io
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FADE = 2'd2
    } state_e;

    state_e            state_q [NOUT];
    state_e            state_d [NOUT];
    logic [LGHOLD-1:0] cnt_q   [NOUT];
    logic [LGHOLD-1:0] cnt_d   [NOUT];
    logic [LGPWM-1:0]  duty_c  [NOUT];

    logic [LGPWM-1:0]  pwm_q;
    logic [LGPWM-1:0]  pwm_d;
    logic [NOUT-1:0]   led_q;
    logic [NOUT-1:0]   led_d;
    logic [NOUT-1:0]   busy_c;
    logic [NOUT-1:0]   event_c;

    assign event_c = led_io.i_event;

    // Shared free-running PWM phase; wraps naturally at 2^LGPWM
    always_comb begin
        pwm_d = pwm_q + LGPWM'(1);
    end

    // Fade duty is the top LGPWM bits of the down-counter
    always_comb begin
        for (int k = 0; k < int'(NOUT); k++) begin
            duty_c[k] = cnt_q[k][LGHOLD-1 -: LGPWM];
        end
    end

    // Per-channel next-state, counter and LED drive; events override every state
    always_comb begin
        for (int k = 0; k < int'(NOUT); k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            led_d[k]   = 1'b0;

            if (event_c[k]) begin
                state_d[k] = ST_HOLD;
                cnt_d[k]   = '1;
            end else begin
                case (state_q[k])
                    ST_HOLD: begin
                        if (cnt_q[k] == '0) begin
                            state_d[k] = ST_FADE;
                            cnt_d[k]   = '1;
                        end else begin
                            cnt_d[k] = cnt_q[k] - LGHOLD'(1);
                        end
                    end
                    ST_FADE: begin
                        if (cnt_q[k] == '0) begin
                            state_d[k] = ST_IDLE;
                        end else begin
                            cnt_d[k] = cnt_q[k] - LGHOLD'(1);
                        end
                    end
                    default: begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = '0;
                    end
                endcase
            end

            led_d[k] = event_c[k]
                     | (state_q[k] == ST_HOLD)
                     | ((state_q[k] == ST_FADE) && (duty_c[k] > pwm_q));
        end
    end

    // Busy is a direct decode of the channel state register
    always_comb begin
        for (int k = 0; k < int'(NOUT); k++) begin
            busy_c[k] = (state_q[k] != ST_IDLE);
        end
    end

    // State, counters, PWM phase and LED register with asynchronous clear
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pwm_q <= '0;
            led_q <= '0;
            for (int k = 0; k < int'(NOUT); k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
            end
        end else begin
            pwm_q <= pwm_d;
            led_q <= led_d;
            for (int k = 0; k < int'(NOUT); k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    assign led_io.o_led  = led_q;
    assign led_io.o_busy = busy_c;

endmodule : led_stretcher

// File: tb/tb_led_stretcher.sv
// Directed scoreboard bench for led_stretcher with a closed-form timing model.
module tb_led_stretcher;

    localparam int unsigned NOUT   = 4;
    localparam int unsigned LGHOLD = 4;
    localparam int unsigned LGPWM  = 4;
    localparam int HLEN   = 1 << LGHOLD;
    localparam int PWMLEN = 1 << LGPWM;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    led_stretcher_if #(.NOUT(NOUT)) bus ();

    led_stretcher #(
        .NOUT   (NOUT),
        .LGHOLD (LGHOLD),
        .LGPWM  (LGPWM)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .led_io    (bus)
    );

    typedef struct packed {
        logic [NOUT-1:0] led;
        logic [NOUT-1:0] busy;
    } exp_t;

    exp_t  exp_q [$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    t        = 0;
    int    last_ev [NOUT];
    string phase    = "init";

    // Expected outputs in cycle tn from the last event cycle of each channel:
    // LED on for d=1..HLEN+1, PWM fade for d=HLEN+2..2*HLEN+1, busy for d=1..2*HLEN.
    function automatic exp_t model(input int tn);
        exp_t e;
        int   d;
        int   cnt;
        int   duty;
        int   pwm;
        e   = '0;
        pwm = (tn - 1) % PWMLEN;
        for (int k = 0; k < int'(NOUT); k++) begin
            d = tn - last_ev[k];
            if (d >= 1 && d <= HLEN + 1) begin
                e.led[k] = 1'b1;
            end else if (d >= HLEN + 2 && d <= 2 * HLEN + 1) begin
                cnt      = 2 * HLEN + 1 - d;
                duty     = cnt >> (LGHOLD - LGPWM);
                e.led[k] = (duty > pwm);
            end
            e.busy[k] = (d >= 1 && d <= 2 * HLEN);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [NOUT-1:0] obs, input logic [NOUT-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s/%s t=%0d observed=%b expected=%b", phase, tag, t, obs, expv);
        end
    endtask

    task automatic reset_model();
        t = 0;
        for (int k = 0; k < int'(NOUT); k++) last_ev[k] = -1000;
    endtask

    // Drive one cycle of events, queue the expectation, then compare next cycle
    task automatic cycle(input logic [NOUT-1:0] ev);
        exp_t e;
        bus.i_event = ev;
        for (int k = 0; k < int'(NOUT); k++) begin
            if (ev[k]) last_ev[k] = t;
        end
        exp_q.push_back(model(t + 1));
        @(posedge clk);
        #1;
        t++;
        e = exp_q.pop_front();
        check("led", bus.o_led, e.led);
        check("busy", bus.o_busy, e.busy);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle('0);
    endtask

    initial begin
        bus.i_event = '1;
        rst_n       = 1'b0;
        reset_model();

        phase = "reset";
        repeat (5) begin
            @(posedge clk);
            #1;
            check("led", bus.o_led, '0);
            check("busy", bus.o_busy, '0);
        end
        bus.i_event = '0;
        rst_n       = 1'b1;
        reset_model();
        check("led0", bus.o_led, '0);
        check("busy0", bus.o_busy, '0);
        idle(3);

        phase = "single";
        cycle(4'b0001);
        idle(40);

        phase = "retrig";
        cycle(4'b0001);
        idle(19);
        cycle(4'b0001);
        idle(40);

        phase = "held";
        repeat (100) cycle(4'b0100);
        idle(40);

        phase = "stagger";
        cycle(4'b0010);
        idle(4);
        cycle(4'b1000);
        idle(45);

        phase = "simul";
        cycle(4'b1111);
        idle(40);

        phase = "async";
        cycle(4'b0001);
        idle(24);
        check("busy_pre", bus.o_busy, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("led_async", bus.o_led, '0);
        check("busy_async", bus.o_busy, '0);
        exp_q.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("led_inrst", bus.o_led, '0);
            check("busy_inrst", bus.o_busy, '0);
        end
        rst_n = 1'b1;
        reset_model();
        phase = "post_rst";
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_led_stretcher

// File: doc/led_stretcher.md
Name: led_stretcher

Overview:
- Output-side counterpart to the input debouncer: converts brief or bouncy internal events into human-visible LED activity.
- Any cycle an event bit is high, its LED turns fully on, stays on for a fixed hold time, then fades out through PWM dimming.
- Sits between status/event logic (bus strobes, errors, debounced buttons) and the board LED pins.

Parameters:
- NOUT, 8, number of independent LED channels.
- LGHOLD, 17, log2 of the hold and fade durations in clocks; must satisfy LGHOLD >= LGPWM.
- LGPWM, 8, width of the shared free-running PWM counter; the PWM period is 2^LGPWM clocks.

Ports:
- i_clk  input  1  system clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_event  input  NOUT  per-channel event request; synchronous to i_clk; level-sensitive.
- o_led  output  NOUT  registered LED drive, active high.
- o_busy  output  NOUT  channel is not IDLE, decoded directly from state registers.

Behaviour:
- Reset, asynchronous, on i_reset_n low:
  - every channel goes to IDLE with cnt=0;
  - pwm=0;
  - o_led=0 and o_busy=0.
  - Reset asserted mid-hold or mid-fade clears immediately.
  - Release is synchronous: the first active edge after release behaves as normal operation.
- Shared pwm counter (LGPWM bits):
  - increments every clock;
  - wraps from 2^LGPWM-1 to 0.
- Per-channel state: IDLE, HOLD, FADE, plus an LGHOLD-bit down-counter cnt.
- Transitions are evaluated every clock, and i_event has priority in all states:
  - i_event[k]=1, any state: go to HOLD and reload cnt to all-ones (2^LGHOLD-1). This retriggers HOLD and FADE, and a held-high input keeps the LED on indefinitely.
  - HOLD, no event: cnt decrements. When cnt==0, go to FADE and reload cnt to all-ones.
  - FADE, no event: cnt decrements. When cnt==0, go to IDLE.
  - IDLE, no event: remain in IDLE with cnt=0.
- Duty in FADE:
  - duty = cnt[LGHOLD-1 -: LGPWM], the top LGPWM bits of cnt;
  - the LED is lit when duty > pwm, unsigned compare;
  - duty falls monotonically, so brightness decays linearly;
  - duty=0 never lights the LED.
- Output register, per clock: o_led[k] <= i_event[k] | (state==HOLD) | (state==FADE & duty>pwm).
- Latency: o_led rises on the clock edge following the first cycle i_event is sampled high, i.e. one cycle of latency.
- Timing for a single-cycle pulse at cycle 0:
  - state is HOLD for cycles 1 .. 2^LGHOLD;
  - o_led=1 for cycles 1 .. 2^LGHOLD+1;
  - state is FADE for cycles 2^LGHOLD+1 .. 2^(LGHOLD+1);
  - o_led is PWM-modulated for cycles 2^LGHOLD+2 .. 2^(LGHOLD+1)+1;
  - IDLE from cycle 2^(LGHOLD+1)+1;
  - o_led=0 from cycle 2^(LGHOLD+1)+2.
- Timing for a multi-cycle event: the timing is measured from the last cycle i_event was high.
- Channel independence: channels share only pwm. Simultaneous events on several channels are handled independently and identically.
- Arithmetic: the cnt decrement occurs only when cnt != 0, so there is no underflow wrap.

Test Plan (NOUT=4, LGHOLD=4, LGPWM=4):
- Reset: hold i_reset_n=0 for 5 clocks with i_event=4'hF -> o_led=0, o_busy=0 throughout. Release with i_event=0 -> both outputs stay 0.
- Single pulse: i_event=4'b0001 at cycle 0 only.
  - o_led[0]=1 for cycles 1..17.
  - For cycles 18..33, o_led[0] equals (cnt>pwm) per a reference model.
  - o_led[0]=0 from cycle 34.
  - o_busy[0] falls at cycle 33.
  - Channels 1..3 remain 0.
- Retrigger in FADE: pulse at cycle 0, second pulse at cycle 20 -> o_led[0]=1 for cycles 21..37, fade for cycles 38..53, then off.
- Held input: i_event[2]=1 for 100 cycles -> o_led[2]=1 continuously from cycle 1 through 17 cycles after the drop, then fade.
- Simultaneous and staggered events: pulse ch1 at cycle 0 and ch3 at cycle 5 -> identical waveforms offset by exactly 5 cycles in state. o_led in FADE differs only by the pwm phase, which must be checked against the model.
- Async reset mid-fade: assert i_reset_n=0 at cycle 25, between clock edges -> o_led and o_busy clear without waiting for a clock edge. After release, no residual activity.
